hld_lock_sequencer: RTL and testbench
=====================================

// Module: hld_lock_sequencer
// PURPOSE
//  Sequences the harmonic-lock-detect (HLD) path of the FMDLL. Arms the HLD latches with a Sel pulse,
//  masks a settle window, then qualifies lock by counting clean DIV_M reference edges. Retries on any
//  Reset_PD assertion and escalates to FAULT after a bounded number of retries.
//  Sits between the top-level enable and the HLD / phase-detector block, in the clk_ext domain.
// PARAMETERS
//  SETTLE_CYC  16  clk_ext cycles Reset_PD is ignored after arming
//  LOCK_CNT    8   consecutive clean DIV_M rising edges required for lock
//  MAX_RETRY   3   retries allowed before FAULT
//  SEL_W       2   width of the Sel arm pulse, in clk_ext cycles
// PORTS
//  clk_ext    in   1  sole clock
//  rst        in   1  asynchronous, active-high reset
//  en         in   1  sequencer enable (synchronous)
//  div_m      in   1  DIV_M divider output, asynchronous; 2-flop synchronised inside
//  reset_pd   in   1  HLD Reset_PD (HLD1|HLD2), asynchronous; 2-flop synchronised inside
//  sel        out  1  arm pulse to the HLD Sel input
//  pd_mask    out  1  high while the phase detector must ignore results (ARM/SETTLE/RECOVER)
//  lock       out  1  lock qualified
//  fault      out  1  retry limit exceeded
//  retry_cnt  out  2  retries since the last LOCKED entry or IDLE
//  state      out  3  current FSM state code
//  hld_events out  16 Reset_PD event count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: every output is 0; state=IDLE; all counters 0; synchroniser flops 0.
//  Edge detection: dm_rise = sync(div_m) rising edge; pd_rise = sync(reset_pd) rising edge.
//   Each is 1 cycle wide. Latency from the pin to the event is 3 clk_ext cycles.
//  FSM codes: IDLE=0 ARM=1 SETTLE=2 TRACK=3 LOCKED=4 RECOVER=5 FAULT=6.
//  en=0 in any state -> IDLE on the next edge. This overrides every transition below.
//  IDLE: all outputs 0, retry_cnt cleared. en=1 -> ARM.
//  ARM: sel=1 for exactly SEL_W cycles, then -> SETTLE. pd_mask=1. good_cnt cleared.
//  SETTLE: timer counts SETTLE_CYC cycles, then -> TRACK. pd_rise is ignored. pd_mask=1.
//  TRACK: pd_mask=0.
//   pd_rise -> RECOVER; good_cnt cleared.
//   Otherwise dm_rise -> good_cnt+1. When good_cnt reaches LOCK_CNT -> LOCKED.
//   If pd_rise and dm_rise arrive in the same cycle, pd_rise wins.
//  LOCKED: lock=1 from the first cycle in the state; retry_cnt cleared on entry.
//   pd_rise -> RECOVER; lock=0 on the next cycle.
//  RECOVER: one cycle, pd_mask=1.
//   If retry_cnt == MAX_RETRY -> FAULT.
//   Else retry_cnt+1 -> ARM.
//  FAULT: fault=1, sel=0, pd_mask=1. Left only via en=0 (-> IDLE) or rst.
//  Counters: good_cnt is wide enough for LOCK_CNT. retry_cnt saturates at MAX_RETRY.
//   The settle timer reloads on every entry to SETTLE.
//  rst during any state: immediate asynchronous return to reset values, including a sel pulse
//   in progress (sel drops at once).
// CONFIGURATION
//  HLD_EVENT_CNT_EN defined:
//   hld_events counts every pd_rise in TRACK or LOCKED.
//   The counter saturates at 16'hFFFF. It is cleared by rst only; en=0 does not clear it.
//  HLD_EVENT_CNT_EN undefined:
//   hld_events is tied to 16'h0000 and no counter flops are built. The port is still present.
// TESTING
//  T1 rst=1 then release, en=0 for 10 cycles -> all outputs 0, state=0.
//  T2 en=1, div_m period 8 cycles, reset_pd=0
//   -> sel high in 2 cycles; TRACK after SEL_W+SETTLE_CYC+1 cycles;
//      lock=1 after the 8th clean DIV_M edge; retry_cnt=0.
//  T3 Locked, pulse reset_pd for 3 cycles
//   -> lock drops 4-5 cycles later; second sel pulse; relock after 8 edges; retry_cnt=0 after relock.
//  T4 reset_pd held high permanently during TRACK
//   -> 3 re-arms (retry_cnt 1,2,3), then fault=1, state=6.
//   Drop en -> state=0 and fault=0 on the next cycle.
//  T5 Align a reset_pd edge with a div_m edge in TRACK -> RECOVER; good_cnt not incremented.
//   A reset_pd pulse inside SETTLE -> ignored; lock still reached.
//  T6 Assert rst mid-ARM (sel=1) -> sel=0 asynchronously.
//   With HLD_EVENT_CNT_EN defined: hld_events=5 after 5 pd events, unchanged by en=0, 0 after rst.

Source files
------------

// File: rtl/hld_lock_sequencer.sv
// Harmonic-lock-detect sequencer: arms the HLD latches, masks settling, then qualifies lock on DIV_M edges.
// Optional Reset_PD event counter is enabled with `define HLD_EVENT_CNT_EN.
module hld_lock_sequencer #(
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned LOCK_CNT   = 8,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned SEL_W      = 2
) (
  input  logic        clk_ext,
  input  logic        rst,
  input  logic        en,
  input  logic        div_m,
  input  logic        reset_pd,
  output logic        sel,
  output logic        pd_mask,
  output logic        lock,
  output logic        fault,
  output logic [1:0]  retry_cnt,
  output logic [2:0]  state,
  output logic [15:0] hld_events
);

  localparam int unsigned TMR_MAX = (SETTLE_CYC > SEL_W) ? SETTLE_CYC : SEL_W;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int unsigned GOOD_W  = $clog2(LOCK_CNT + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_TRACK   = 3'd3,
    ST_LOCKED  = 3'd4,
    ST_RECOVER = 3'd5,
    ST_FAULT   = 3'd6
  } state_t;

  state_t             r_state;
  logic [2:0]         r_dm_sync;
  logic [2:0]         r_pd_sync;
  logic [TMR_W-1:0]   r_timer;
  logic [GOOD_W-1:0]  r_good;
  logic [1:0]         r_retry;
  logic               r_sel;
  logic               r_mask;
  logic               r_lock;
  logic               r_fault;
  logic               w_dm_rise;
  logic               w_pd_rise;

  // Two flops resynchronise; the third holds the previous level for edge detection.
  always_ff @(posedge clk_ext or posedge rst) begin
    if (rst) begin
      r_dm_sync <= '0;
      r_pd_sync <= '0;
    end else begin
      r_dm_sync <= {r_dm_sync[1:0], div_m};
      r_pd_sync <= {r_pd_sync[1:0], reset_pd};
    end
  end

  assign w_dm_rise = r_dm_sync[1] & ~r_dm_sync[2];
  assign w_pd_rise = r_pd_sync[1] & ~r_pd_sync[2];

  always_ff @(posedge clk_ext or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_good  <= '0;
      r_retry <= '0;
      r_sel   <= 1'b0;
      r_mask  <= 1'b0;
      r_lock  <= 1'b0;
      r_fault <= 1'b0;
    end else if (!en) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_good  <= '0;
      r_retry <= '0;
      r_sel   <= 1'b0;
      r_mask  <= 1'b0;
      r_lock  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_ARM;
          r_sel   <= 1'b1;
          r_mask  <= 1'b1;
          r_timer <= '0;
          r_good  <= '0;
        end
        ST_ARM: begin
          if (r_timer == TMR_W'(SEL_W - 1)) begin
            r_state <= ST_SETTLE;
            r_sel   <= 1'b0;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (r_timer == TMR_W'(SETTLE_CYC - 1)) begin
            r_state <= ST_TRACK;
            r_mask  <= 1'b0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_TRACK: begin
          // A coincident DIV_M edge is discarded when Reset_PD fires.
          if (w_pd_rise) begin
            r_state <= ST_RECOVER;
            r_mask  <= 1'b1;
            r_good  <= '0;
          end else if (w_dm_rise) begin
            r_good <= r_good + 1'b1;
            if (r_good == GOOD_W'(LOCK_CNT - 1)) begin
              r_state <= ST_LOCKED;
              r_lock  <= 1'b1;
              r_retry <= '0;
            end
          end
        end
        ST_LOCKED: begin
          if (w_pd_rise) begin
            r_state <= ST_RECOVER;
            r_lock  <= 1'b0;
            r_mask  <= 1'b1;
          end
        end
        ST_RECOVER: begin
          if (r_retry == 2'(MAX_RETRY)) begin
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
          end else begin
            r_state <= ST_ARM;
            r_retry <= r_retry + 2'd1;
            r_sel   <= 1'b1;
            r_timer <= '0;
            r_good  <= '0;
          end
        end
        ST_FAULT: begin
          r_state <= ST_FAULT;
        end
        default: begin
          r_state <= ST_IDLE;
          r_sel   <= 1'b0;
          r_mask  <= 1'b0;
          r_lock  <= 1'b0;
          r_fault <= 1'b0;
        end
      endcase
    end
  end

`ifdef HLD_EVENT_CNT_EN
  logic [15:0] r_events;

  // Survives en=0 so software can read the history after disabling.
  always_ff @(posedge clk_ext or posedge rst) begin
    if (rst) begin
      r_events <= '0;
    end else if (w_pd_rise && (r_state == ST_TRACK || r_state == ST_LOCKED) && (r_events != '1)) begin
      r_events <= r_events + 16'd1;
    end
  end

  assign hld_events = r_events;
`else
  assign hld_events = '0;
`endif

  assign sel       = r_sel;
  assign pd_mask   = r_mask;
  assign lock      = r_lock;
  assign fault     = r_fault;
  assign retry_cnt = r_retry;
  assign state     = r_state;

endmodule

// File: tb/tb_hld_lock_sequencer.sv
// Self-checking bench for hld_lock_sequencer: directed scenarios plus randomized traffic
// compared cycle-by-cycle with a time-based reference model.
module tb_hld_lock_sequencer;

  localparam int SETTLE_CYC = 16;
  localparam int LOCK_CNT   = 8;
  localparam int MAX_RETRY  = 3;
  localparam int SEL_W      = 2;

  logic        clk_ext = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        div_m = 1'b0;
  logic        reset_pd = 1'b0;
  logic        sel, pd_mask, lock, fault;
  logic [1:0]  retry_cnt;
  logic [2:0]  state;
  logic [15:0] hld_events;

  int tests = 0;
  int fails = 0;

  hld_lock_sequencer #(
    .SETTLE_CYC(SETTLE_CYC),
    .LOCK_CNT  (LOCK_CNT),
    .MAX_RETRY (MAX_RETRY),
    .SEL_W     (SEL_W)
  ) dut (
    .clk_ext   (clk_ext),
    .rst       (rst),
    .en        (en),
    .div_m     (div_m),
    .reset_pd  (reset_pd),
    .sel       (sel),
    .pd_mask   (pd_mask),
    .lock      (lock),
    .fault     (fault),
    .retry_cnt (retry_cnt),
    .state     (state),
    .hld_events(hld_events)
  );

  always #5 clk_ext = ~clk_ext;

  // Reference model: phase code, age since arming began, clean-edge tally, retries, events.
  int m_mode, m_age, m_good, m_retry, m_events;
  int dm_pins[$];
  int pd_pins[$];
  int dm_half = 0;
  int dm_cnt  = 0;

  task automatic model_reset();
    m_mode = 0; m_age = 0; m_good = 0; m_retry = 0; m_events = 0;
    dm_pins = '{0, 0, 0};
    pd_pins = '{0, 0, 0};
  endtask

  // Pin levels seen at edge n are acted on at edge n+2 (two sync flops).
  task automatic model_step();
    bit dm_ev, pd_ev;
    if (rst) begin
      model_reset();
      return;
    end
    dm_ev = (dm_pins[1] == 1) && (dm_pins[0] == 0);
    pd_ev = (pd_pins[1] == 1) && (pd_pins[0] == 0);
    if (pd_ev && (m_mode == 3 || m_mode == 4) && m_events < 65535) m_events++;
    if (!en) begin
      m_mode = 0; m_retry = 0; m_good = 0;
    end else begin
      case (m_mode)
        0: begin m_mode = 1; m_age = 0; m_good = 0; end
        1, 2: begin
          m_age++;
          if (m_age == SEL_W + SETTLE_CYC) m_mode = 3;
          else m_mode = (m_age < SEL_W) ? 1 : 2;
        end
        3: begin
          if (pd_ev) begin m_mode = 5; m_good = 0; end
          else if (dm_ev) begin
            m_good++;
            if (m_good == LOCK_CNT) begin m_mode = 4; m_retry = 0; end
          end
        end
        4: if (pd_ev) m_mode = 5;
        5: begin
          if (m_retry == MAX_RETRY) m_mode = 6;
          else begin m_retry++; m_mode = 1; m_age = 0; m_good = 0; end
        end
        default: ;
      endcase
    end
    void'(dm_pins.pop_front());
    dm_pins.push_back(int'(div_m));
    void'(pd_pins.pop_front());
    pd_pins.push_back(int'(reset_pd));
  endtask

  task automatic tick();
    @(posedge clk_ext);
    model_step();
    #1;
    if (dm_half != 0) begin
      dm_cnt++;
      if (dm_cnt >= dm_half) begin dm_cnt = 0; div_m = ~div_m; end
    end
  endtask

  function automatic logic [24:0] dut_vec();
    return {state, sel, pd_mask, lock, fault, retry_cnt, hld_events};
  endfunction

  function automatic logic [24:0] exp_vec();
    logic [15:0] ev;
`ifdef HLD_EVENT_CNT_EN
    ev = 16'(m_events);
`else
    ev = '0;
`endif
    return {3'(m_mode), m_mode == 1, (m_mode inside {1, 2, 5, 6}), m_mode == 4, m_mode == 6,
            2'(m_retry), ev};
  endfunction

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; div_m = 1'b0; reset_pd = 1'b0; dm_half = 0; dm_cnt = 0;
    model_reset();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (dut_vec() !== 25'd0) begin
        fails++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=0", i, dut_vec());
      end
    end
  endtask

  task automatic test_lock();
    int k;
    bit done;
    dm_half = 4; dm_cnt = 0;
    en = 1'b1;
    done = 0;
    for (k = 1; k <= 400 && !done; k++) begin
      tick();
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL lock_seq k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      end
      if (k == 1) begin
        tests++;
        if (sel !== 1'b1) begin fails++; $display("FAIL sel_start got=%b exp=1", sel); end
      end
      if (k == SEL_W + SETTLE_CYC) begin
        tests++;
        if (state !== 3'd2) begin fails++; $display("FAIL settle_end got=%0d exp=2", state); end
      end
      if (k == SEL_W + SETTLE_CYC + 1) begin
        tests++;
        if (state !== 3'd3) begin fails++; $display("FAIL track_entry got=%0d exp=3", state); end
      end
      if (m_mode == 4) done = 1;
    end
    tests++;
    if (!done || lock !== 1'b1 || retry_cnt !== 2'd0) begin
      fails++;
      $display("FAIL lock_reached lock=%b retry=%0d exp lock=1 retry=0", lock, retry_cnt);
    end
  endtask

  task automatic test_relock();
    int sel_cycles;
    bit dropped, done;
    sel_cycles = 0; dropped = 0; done = 0;
    reset_pd = 1'b1;
    for (int k = 1; k <= 600 && !done; k++) begin
      tick();
      if (k == 3) reset_pd = 1'b0;
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL relock_seq k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      end
      if (k <= 6 && lock === 1'b0) dropped = 1;
      if (sel === 1'b1) sel_cycles++;
      if (k > 6 && m_mode == 4) done = 1;
    end
    tests++;
    if (!dropped) begin fails++; $display("FAIL lock_drop got=held exp=dropped_within_6"); end
    tests++;
    if (sel_cycles != SEL_W) begin
      fails++; $display("FAIL sel_width got=%0d exp=%0d", sel_cycles, SEL_W);
    end
    tests++;
    if (!done || lock !== 1'b1 || retry_cnt !== 2'd0) begin
      fails++;
      $display("FAIL relock lock=%b retry=%0d exp lock=1 retry=0", lock, retry_cnt);
    end
  endtask

  task automatic test_fault();
    bit seen;
    dm_half = 0; div_m = 1'b0; reset_pd = 1'b0;
    en = 1'b0; tick(); en = 1'b1;
    for (int r = 0; r <= MAX_RETRY; r++) begin
      seen = 0;
      for (int k = 0; k < 200 && !seen; k++) begin
        tick();
        tests++;
        if (dut_vec() !== exp_vec()) begin
          fails++;
          $display("FAIL fault_seq r=%0d got=%h exp=%h", r, dut_vec(), exp_vec());
        end
        if (m_mode == 3) seen = 1;
      end
      if (!seen) begin fails++; $display("FAIL fault_track_wait r=%0d got=timeout exp=TRACK", r); end
      reset_pd = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      reset_pd = 1'b0;
      tests++;
      if (r < MAX_RETRY && retry_cnt !== 2'(r + 1)) begin
        fails++; $display("FAIL retry_step r=%0d got=%0d exp=%0d", r, retry_cnt, r + 1);
      end
    end
    tests++;
    if (state !== 3'd6 || fault !== 1'b1 || pd_mask !== 1'b1 || sel !== 1'b0) begin
      fails++;
      $display("FAIL fault_state st=%0d fault=%b mask=%b sel=%b exp 6/1/1/0", state, fault, pd_mask, sel);
    end
    en = 1'b0;
    tick();
    tests++;
    if (state !== 3'd0 || fault !== 1'b0 || retry_cnt !== 2'd0) begin
      fails++; $display("FAIL fault_exit st=%0d fault=%b retry=%0d exp 0/0/0", state, fault, retry_cnt);
    end
  endtask

  task automatic test_collision();
    bit seen;
    dm_half = 0; div_m = 1'b0; reset_pd = 1'b0;
    en = 1'b1;
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin tick(); if (m_mode == 3) seen = 1; end
    for (int e = 0; e < 3; e++) begin
      div_m = 1'b1; tick(); tick();
      div_m = 1'b0; tick(); tick();
    end
    div_m = 1'b1; reset_pd = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    tests++;
    if (!seen || state !== 3'd5) begin
      fails++; $display("FAIL collision_recover got=%0d exp=5", state);
    end
    reset_pd = 1'b0; div_m = 1'b0;
    dm_half = 2; dm_cnt = 0;
    seen = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      tick();
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL collision_seq k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      end
      if (m_mode == 4) seen = 1;
    end
    tests++;
    if (!seen || retry_cnt !== 2'd0) begin
      fails++; $display("FAIL collision_relock retry=%0d exp=0", retry_cnt);
    end
  endtask

  task automatic test_settle_ignore();
    bit done, recovered;
    en = 1'b0; dm_half = 3; dm_cnt = 0; tick();
    en = 1'b1;
    done = 0; recovered = 0;
    for (int k = 1; k <= 300 && !done; k++) begin
      tick();
      if (k == SEL_W + 3) reset_pd = 1'b1;
      if (k == SEL_W + 5) reset_pd = 1'b0;
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL settle_seq k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      end
      if (state === 3'd5) recovered = 1;
      if (m_mode == 4) done = 1;
    end
    tests++;
    if (!done || recovered || lock !== 1'b1) begin
      fails++; $display("FAIL settle_ignore lock=%b recovered=%b exp lock=1 recovered=0", lock, recovered);
    end
  endtask

  task automatic test_async_reset();
    en = 1'b0; dm_half = 0; div_m = 1'b0; tick();
    en = 1'b1; tick();
    tests++;
    if (sel !== 1'b1) begin fails++; $display("FAIL arm_sel got=%b exp=1", sel); end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (sel !== 1'b0 || state !== 3'd0 || pd_mask !== 1'b0) begin
      fails++; $display("FAIL async_rst sel=%b st=%0d mask=%b exp 0/0/0", sel, state, pd_mask);
    end
    model_reset();
    tick();
    rst = 1'b0; en = 1'b0;
  endtask

  task automatic test_events();
    bit seen;
    logic [15:0] exp5;
`ifdef HLD_EVENT_CNT_EN
    exp5 = 16'd5;
`else
    exp5 = 16'd0;
`endif
    do_reset();
    en = 1'b1;
    for (int r = 0; r < 5; r++) begin
      if (r == MAX_RETRY + 1) begin en = 1'b0; tick(); en = 1'b1; end
      seen = 0;
      for (int k = 0; k < 200 && !seen; k++) begin tick(); if (m_mode == 3) seen = 1; end
      if (!seen) begin fails++; $display("FAIL events_wait r=%0d got=timeout exp=TRACK", r); end
      reset_pd = 1'b1; tick(); tick(); reset_pd = 1'b0;
      for (int k = 0; k < 4; k++) tick();
    end
    tests++;
    if (hld_events !== exp5) begin fails++; $display("FAIL events_count got=%0d exp=%0d", hld_events, exp5); end
    en = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    tests++;
    if (hld_events !== exp5) begin fails++; $display("FAIL events_en0 got=%0d exp=%0d", hld_events, exp5); end
    rst = 1'b1; #1;
    tests++;
    if (hld_events !== 16'd0) begin fails++; $display("FAIL events_rst got=%0d exp=0", hld_events); end
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_random();
    int pd_left;
    for (int t = 0; t < 4; t++) begin
      do_reset();
      dm_half = int'($urandom_range(1, 6)); dm_cnt = 0;
      en = 1'b1; pd_left = 0;
      for (int k = 0; k < 1500; k++) begin
        tick();
        tests++;
        if (dut_vec() !== exp_vec()) begin
          fails++; $display("FAIL random t=%0d k=%0d got=%h exp=%h", t, k, dut_vec(), exp_vec());
        end
        if (en && $urandom_range(0, 399) == 0) en = 1'b0;
        else if (!en && $urandom_range(0, 4) == 0) en = 1'b1;
        if (pd_left > 0) begin
          pd_left--;
          if (pd_left == 0) reset_pd = 1'b0;
        end else if ($urandom_range(0, 149) == 0) begin
          reset_pd = 1'b1; pd_left = int'($urandom_range(1, 4));
        end
      end
      reset_pd = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_relock();
    test_fault();
    test_collision();
    test_settle_ignore();
    test_async_reset();
    test_events();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
